// File: rtl/pwm_multi_pkg.sv
// Shared types and helpers for the multi-channel PWM block.
// Direction encoding, mode constants and dead-time counter sizing.
package pwm_multi_pkg;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  localparam logic MODE_EDGE   = 1'b0;
  localparam logic MODE_CENTER = 1'b1;

  function automatic int dt_cnt_width(input int dt);
    return (dt < 1) ? 1 : $clog2(dt + 1);
  endfunction

endpackage

// File: rtl/pwm_deadtime.sv
// Per-channel dead-time inserter producing a complementary pair.
// Both legs stay low for DEADTIME cycles after each raw edge.
module pwm_deadtime
  import pwm_multi_pkg::*;
#(
  parameter int DEADTIME = 4
) (
  input  logic clk,
  input  logic nreset,
  input  logic raw,
  output logic p,
  output logic n
);

  localparam int CW = dt_cnt_width(DEADTIME);
  localparam logic [CW-1:0] Reload = CW'(DEADTIME - 1);
  localparam logic [CW-1:0] One = CW'(1);

  logic          prev_q, prev_d;
  logic          p_q, p_d;
  logic          n_q, n_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (!nreset) begin
      prev_q <= 1'b0;
      p_q    <= 1'b0;
      n_q    <= 1'b0;
      cnt_q  <= '0;
    end else begin
      prev_q <= prev_d;
      p_q    <= p_d;
      n_q    <= n_d;
      cnt_q  <= cnt_d;
    end
  end

  // An edge restarts the blanking window, so short pulses never escape.
  always_comb begin
    prev_d = raw;
    cnt_d  = cnt_q;
    p_d    = raw;
    n_d    = ~raw;
    if ((raw != prev_q) && (DEADTIME > 0)) begin
      cnt_d = Reload;
      p_d   = 1'b0;
      n_d   = 1'b0;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - One;
      p_d   = 1'b0;
      n_d   = 1'b0;
    end
  end

  assign p = p_q;
  assign n = n_q;

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM with a shared frame counter and double-buffered config.
// Define PWM_MULTI_DEADTIME_EN for complementary outputs with dead time.
module pwm_multi
  import pwm_multi_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  parameter int DEADTIME = 4
) (
  input  logic                      clk,
  input  logic                      nreset,
  input  logic                      load,
  input  logic [WIDTH-1:0]          period,
  input  logic [CHANNELS*WIDTH-1:0] duty,
  input  logic                      center,
  output logic [CHANNELS-1:0]       out,
`ifdef PWM_MULTI_DEADTIME_EN
  output logic [CHANNELS-1:0]       out_n,
`endif
  output logic                      frame_end
);

  localparam logic [WIDTH-1:0] One = WIDTH'(1);
  localparam logic [WIDTH-1:0] Two = WIDTH'(2);

  logic [WIDTH-1:0]          cnt_q, cnt_d;
  dir_e                      dir_q, dir_d;
  logic [WIDTH-1:0]          per_a_q, per_a_d;
  logic [CHANNELS*WIDTH-1:0] duty_a_q, duty_a_d;
  logic                      ctr_a_q, ctr_a_d;
  logic [WIDTH-1:0]          per_s_q, per_s_d;
  logic [CHANNELS*WIDTH-1:0] duty_s_q, duty_s_d;
  logic                      ctr_s_q, ctr_s_d;
  logic                      pend_q, pend_d;
  logic [CHANNELS-1:0]       cmp_q, cmp_d;
  logic                      fe_q, fe_d;

  logic             idle;
  logic             edge_run;
  logic             ctr_up;
  logic             ctr_dn;
  logic             last;
  logic             pend_eff;
  logic             xfer;
  logic [WIDTH-1:0] per_m1;

  always_ff @(posedge clk) begin
    if (!nreset) begin
      cnt_q    <= '0;
      dir_q    <= DIR_UP;
      per_a_q  <= '0;
      duty_a_q <= '0;
      ctr_a_q  <= MODE_EDGE;
      per_s_q  <= '0;
      duty_s_q <= '0;
      ctr_s_q  <= MODE_EDGE;
      pend_q   <= 1'b0;
      cmp_q    <= '0;
      fe_q     <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      dir_q    <= dir_d;
      per_a_q  <= per_a_d;
      duty_a_q <= duty_a_d;
      ctr_a_q  <= ctr_a_d;
      per_s_q  <= per_s_d;
      duty_s_q <= duty_s_d;
      ctr_s_q  <= ctr_s_d;
      pend_q   <= pend_d;
      cmp_q    <= cmp_d;
      fe_q     <= fe_d;
    end
  end

  // Center mode needs at least two counts; otherwise it runs as edge mode.
  assign idle     = (per_a_q == '0);
  assign per_m1   = per_a_q - One;
  assign edge_run = !idle &&
                    ((ctr_a_q == MODE_EDGE) || (per_a_q < Two));
  assign ctr_up   = !idle && !edge_run && (dir_q == DIR_UP);
  assign ctr_dn   = !idle && !edge_run && (dir_q == DIR_DOWN);

  always_comb begin
    cnt_d = cnt_q;
    dir_d = dir_q;
    last  = 1'b0;
    unique case (1'b1)
      idle: begin
        cnt_d = '0;
        dir_d = DIR_UP;
      end
      edge_run: begin
        dir_d = DIR_UP;
        if (cnt_q >= per_m1) begin
          last  = 1'b1;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + One;
        end
      end
      ctr_up: begin
        if (cnt_q >= per_m1) begin
          if (per_m1 == One) begin
            last  = 1'b1;
            cnt_d = '0;
          end else begin
            dir_d = DIR_DOWN;
            cnt_d = cnt_q - One;
          end
        end else begin
          cnt_d = cnt_q + One;
        end
      end
      ctr_dn: begin
        if (cnt_q <= One) begin
          last  = 1'b1;
          cnt_d = '0;
          dir_d = DIR_UP;
        end else begin
          cnt_d = cnt_q - One;
        end
      end
      default: ;
    endcase

    // A load on the transfer edge bypasses the shadow straight to active.
    pend_eff = pend_q | load;
    xfer     = pend_eff & (last | idle);
    per_s_d  = load ? period : per_s_q;
    duty_s_d = load ? duty : duty_s_q;
    ctr_s_d  = load ? center : ctr_s_q;
    per_a_d  = per_a_q;
    duty_a_d = duty_a_q;
    ctr_a_d  = ctr_a_q;
    pend_d   = pend_eff;
    if (xfer) begin
      per_a_d  = per_s_d;
      duty_a_d = duty_s_d;
      ctr_a_d  = ctr_s_d;
      pend_d   = 1'b0;
      cnt_d    = '0;
      dir_d    = DIR_UP;
    end
  end

  always_comb begin
    cmp_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      cmp_d[i] = !idle &&
                 (cnt_q < duty_a_q[i*WIDTH +: WIDTH]);
    end
    fe_d = last;
  end

  assign frame_end = fe_q;

`ifdef PWM_MULTI_DEADTIME_EN
  for (genvar g = 0; g < CHANNELS; g++) begin : g_dt
    pwm_deadtime #(
      .DEADTIME(DEADTIME)
    ) u_dt (
      .clk   (clk),
      .nreset(nreset),
      .raw   (cmp_q[g]),
      .p     (out[g]),
      .n     (out_n[g])
    );
  end
`else
  assign out = cmp_q;
  if (DEADTIME < 0) begin : g_dt_unused
  end
`endif

endmodule

// File: tb/tb_pwm_multi.sv
// Scoreboard bench for pwm_multi driven by a frame-position model.
// Expected outputs are queued before each edge and popped after it.
module tb_pwm_multi;

  localparam int W  = 16;
  localparam int CH = 4;
  localparam int DT = 2;

  logic            clk = 1'b0;
  logic            nreset;
  logic            load;
  logic [W-1:0]    period;
  logic [CH*W-1:0] duty;
  logic            center;
  logic [CH-1:0]   out;
  logic [CH-1:0]   out_n_w;
  logic            frame_end;

  always #5 clk = ~clk;

  pwm_multi #(
    .WIDTH(W),
    .CHANNELS(CH),
    .DEADTIME(DT)
  ) dut (
    .clk      (clk),
    .nreset   (nreset),
    .load     (load),
    .period   (period),
    .duty     (duty),
    .center   (center),
    .out      (out),
`ifdef PWM_MULTI_DEADTIME_EN
    .out_n    (out_n_w),
`endif
    .frame_end(frame_end)
  );

`ifndef PWM_MULTI_DEADTIME_EN
  assign out_n_w = '0;
`endif

  typedef struct packed {
    logic [CH-1:0] o;
    logic [CH-1:0] on;
    logic          fe;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  int            mpa, mps, mpos;
  int            mda[CH];
  int            mds[CH];
  bit            mca, mcs, mpend;
  logic [CH-1:0] rh[DT+1];

  function automatic int flen();
    return (mca && mpa >= 2) ? 2*mpa - 2 : mpa;
  endfunction

  function automatic bit m_last();
    return (mpa != 0) && (mpos == flen() - 1);
  endfunction

  function automatic int m_cnt();
    if (mca && mpa >= 2 && mpos >= mpa) return 2*mpa - 2 - mpos;
    return mpos;
  endfunction

  task automatic step();
    exp_t          e, got;
    logic [CH-1:0] r, pa, na;
    bit            lst, pe, xf;
    r  = '0;
    pa = '1;
    na = '1;
    for (int i = 0; i < CH; i++)
      r[i] = (mpa != 0) && (m_cnt() < mda[i]);
    for (int k = 0; k <= DT; k++) begin
      pa &= rh[k];
      na &= ~rh[k];
    end
    lst = m_last();
    if (!nreset) begin
      r = '0; pa = '0; na = '0; lst = 1'b0;
    end
`ifdef PWM_MULTI_DEADTIME_EN
    e.o  = pa;
    e.on = na;
`else
    e.o  = r;
    e.on = '0;
`endif
    e.fe = lst;
    sb.push_back(e);
    for (int k = DT; k > 0; k--) rh[k] = rh[k-1];
    rh[0] = r;
    if (!nreset) begin
      mpa = 0; mps = 0; mpos = 0; mca = 0; mcs = 0; mpend = 0;
      for (int i = 0; i < CH; i++) begin mda[i] = 0; mds[i] = 0; end
      for (int k = 0; k <= DT; k++) rh[k] = '0;
    end else begin
      pe = mpend || load;
      xf = pe && (lst || mpa == 0);
      if (load) begin
        mps = int'(period);
        mcs = center;
        for (int i = 0; i < CH; i++) mds[i] = int'(duty[i*W +: W]);
      end
      if (xf) begin
        mpa = mps; mca = mcs; mda = mds; mpos = 0; mpend = 0;
      end else begin
        mpos  = (mpa == 0 || lst) ? 0 : mpos + 1;
        mpend = pe;
      end
    end
    @(posedge clk);
    #1;
    got = '{o: out, on: out_n_w, fe: frame_end};
    e = sb.pop_front();
    checks++;
    assert (got.o === e.o) else begin
      errors++;
      $error("FAIL out: got %b want %b at %0t", got.o, e.o, $time);
    end
    checks++;
    assert (got.fe === e.fe) else begin
      errors++;
      $error("FAIL frame_end: got %b want %b at %0t", got.fe, e.fe, $time);
    end
`ifdef PWM_MULTI_DEADTIME_EN
    checks++;
    assert (got.on === e.on) else begin
      errors++;
      $error("FAIL out_n: got %b want %b at %0t", got.on, e.on, $time);
    end
`endif
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic do_load(input int p, input logic [CH*W-1:0] d,
                         input logic c);
    period = W'(p);
    duty   = d;
    center = c;
    load   = 1'b1;
    step();
    load   = 1'b0;
  endtask

  initial begin
    nreset = 1'b0; load = 1'b0; period = '0; duty = '0; center = 1'b0;
    mpa = 0; mps = 0; mpos = 0; mca = 0; mcs = 0; mpend = 0;
    for (int i = 0; i < CH; i++) begin mda[i] = 0; mds[i] = 0; end
    for (int k = 0; k <= DT; k++) rh[k] = '0;
    run(2);
    nreset = 1'b1;
    run(100);

    do_load(10, {16'd12, 16'd10, 16'd3, 16'd0}, 1'b0);
    run(34);
    do_load(5, {16'd12, 16'd10, 16'd1, 16'd0}, 1'b0);
    run(24);

    do_load(8, {16'd0, 16'd4, 16'd4, 16'd8}, 1'b0);
    do_load(6, {16'd0, 16'd1, 16'd2, 16'd6}, 1'b0);
    run(20);

    for (int k = 0; k < 50 && !m_last(); k++) step();
    do_load(7, {16'd7, 16'd5, 16'd2, 16'd1}, 1'b0);
    run(16);

    do_load(4, {16'd4, 16'd3, 16'd2, 16'd1}, 1'b1);
    run(24);
    do_load(2, {16'd0, 16'd2, 16'd1, 16'd0}, 1'b1);
    run(8);
    do_load(1, {16'd0, 16'd1, 16'd1, 16'd0}, 1'b1);
    run(8);

    do_load(9, {16'd9, 16'd5, 16'd2, 16'd0}, 1'b0);
    run(12);
    do_load(3, {16'd3, 16'd2, 16'd1, 16'd1}, 1'b0);
    run(2);
    nreset = 1'b0;
    step();
    nreset = 1'b1;
    run(12);

    do_load(10, {16'd10, 16'd0, 16'd5, 16'd1}, 1'b0);
    run(40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
